// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller front end: arbiter states,
// default bus widths and the controller command encodings.
package sdram_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE
  } arb_state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } mem_cmd_e;

  function automatic mem_cmd_e cmd_from_we(input logic we);
    return we ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester ports plus the controller bus side of the SDRAM arbiter.
// slave = arbiter view, master = requesters/controller view.
interface sdram_arbiter_if
  import sdram_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ack;
  logic [DATA_W-1:0]              resp_rdata;

  logic [ADDR_W-1:0]              mem_addr;
  logic                           mem_wrreq;
  logic                           mem_rereq;
  logic [DATA_W-1:0]              mem_wdata;
  logic [DATA_W-1:0]              mem_rdata;
  logic                           mem_busy;
  logic                           mem_done;

  logic [IW-1:0]                  grant_id;
  logic                           timeout_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
           mem_rdata, mem_busy, mem_done,
    output req_ack, resp_rdata, mem_addr, mem_wrreq, mem_rereq, mem_wdata,
           grant_id, timeout_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
           mem_rdata, mem_busy, mem_done,
    input  req_ack, resp_rdata, mem_addr, mem_wrreq, mem_rereq, mem_wdata,
           grant_id, timeout_err
  );

endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting port after last_i,
// wrapping, so the previous winner has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  // rot[k] is the request of port (last_i + 1 + k) mod NUM_REQ
  assign rot = NUM_REQ'({req_i, req_i} >> ({1'b0, last_i} + 1'b1));

  always_comb begin
    valid_o = 1'b0;
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid_o = 1'b1;
        off     = IW'(k);
      end
    end
    sum = {1'b0, last_i} + (IW+1)'(1) + {1'b0, off};
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    idx_o = sum[IW-1:0];
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one single-access SDRAM controller between
// NUM_REQ requesters, with per-access completion timeout.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  sdram_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_e         state_q, state_d;
  req_t               lat_q, lat_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q;
  logic               wrreq_q, wrreq_d;
  logic               rereq_q, rereq_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [DATA_W-1:0]  mwdata_q, mwdata_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic               done_rise;
  mem_cmd_e           cmd;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  // mem_done is a long level; only its first sampled cycle completes an access
  assign done_rise = bus.mem_done & ~done_q;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wrreq_d  = wrreq_q;
    rereq_d  = rereq_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cmd      = CMD_NOP;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld && !bus.mem_busy) begin
          lat_d   = '{we:    bus.req_we[pick_idx],
                      addr:  bus.req_addr[pick_idx],
                      wdata: bus.req_wdata[pick_idx]};
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cmd      = cmd_from_we(lat_q.we);
        wrreq_d  = (cmd == CMD_WRITE);
        rereq_d  = (cmd == CMD_READ);
        maddr_d  = lat_q.addr;
        mwdata_d = lat_q.wdata;
        cnt_d    = cnt_q + 1'b1;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        if (done_rise) begin
          rdata_d        = bus.mem_rdata;
          ack_d[grant_q] = 1'b1;
          wrreq_d        = 1'b0;
          rereq_d        = 1'b0;
          last_d         = grant_q;
          state_d        = ST_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_d          = 1'b1;
          rdata_d        = '0;
          ack_d[grant_q] = 1'b1;
          wrreq_d        = 1'b0;
          rereq_d        = 1'b0;
          last_d         = grant_q;
          state_d        = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.mem_done && !bus.mem_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      grant_q  <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      cnt_q    <= '0;
      done_q   <= 1'b0;
      wrreq_q  <= 1'b0;
      rereq_q  <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      done_q   <= bus.mem_done;
      wrreq_q  <= wrreq_d;
      rereq_q  <= rereq_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.mem_addr    = maddr_q;
  assign bus.mem_wrreq   = wrreq_q;
  assign bus.mem_rereq   = rereq_q;
  assign bus.mem_wdata   = mwdata_q;
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = err_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single-access SDRAM controller between NUM_REQ requesters, such as the CPU bus, a video fetch, and a DMA. Each requester gets one outstanding access at a time, with round-robin fairness. The block sits between requester ports and the controller's bus side (address, wrreq/rereq, write data, read data, busy, done). It serialises accesses, returns read data, and flags any access the controller fails to finish within a timeout.

## Interface
- NUM_REQ, 4: number of requester ports, 2..8
- ADDR_W, 23: word address width
- DATA_W, 16: data width
- TIMEOUT, 64: cycles allowed from issue to controller done
- clk  in  1  system clock, same clock as the controller
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-port request, held until req_ack
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ×ADDR_W  per-port address
- req_wdata  in  NUM_REQ×DATA_W  per-port write data
- req_ack  out  NUM_REQ  one-cycle pulse: port's access completed
- resp_rdata  out  DATA_W  read data, valid with req_ack of a read
- mem_addr  out  ADDR_W  to controller addrin
- mem_wrreq, mem_rereq  out  1  to controller; at most one high
- mem_wdata  out  DATA_W  to controller datain
- mem_rdata  in  DATA_W  from controller dataout
- mem_busy  in  1  controller rw_busy
- mem_done  in  1  controller rwdone_w (level, high several cycles)
- grant_id  out  $clog2(NUM_REQ)  port currently owning the controller
- timeout_err  out  1  sticky; cleared only by rst

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE:
  - If any req_valid is high and mem_busy = 0, pick the winner round-robin, starting from the port after last_grant.
  - Latch the winner's we/addr/wdata into registers, set grant_id, go to ISSUE.
- ISSUE:
  - Drive mem_wrreq = we or mem_rereq = !we, plus mem_addr and mem_wdata from the latched registers.
  - Hold all of them stable; go to WAIT_DONE.
- WAIT_DONE:
  - Keep driving the request.
  - On the first cycle mem_done is sampled high (rising edge vs. the registered done_q), capture mem_rdata into resp_rdata. Pulse req_ack[grant_id], drop mem_wrreq/mem_rereq, update last_grant, go to RELEASE.
  - The timeout counter increments each cycle spent in ISSUE or WAIT_DONE. On reaching TIMEOUT: set timeout_err, pulse req_ack (resp_rdata = 0), go to RELEASE.
- RELEASE: wait until mem_done = 0 and mem_busy = 0, then go to IDLE. This prevents double-counting the long done level.
- Requester must hold valid/we/addr/wdata until req_ack. Changes after the IDLE latch are ignored.
- A requester may re-assert req_valid on the cycle after req_ack. Round-robin still moves the pointer past it.
- A requester dropping req_valid before ack: the access still completes and ack still pulses.
- The latched request is never modified by other ports.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM_REQ-1 (port 0 wins first), grant_id = 0
  - all mem_* outputs 0, req_ack = 0, resp_rdata = 0, timeout_err = 0, counter = 0
- Issue latency: req_valid sampled in IDLE at cycle 0 → mem_wrreq/mem_rereq high from cycle 2 (register latch, then ISSUE).
- Completion: req_ack and resp_rdata are registered, valid the cycle after the mem_done rising edge is sampled.
- mem_busy high in IDLE stalls arbitration (controller refresh). No request is issued while it is high.
- Timeout counter: $clog2(TIMEOUT+1) bits, cleared on entry to ISSUE, saturates.
- rst mid-access: all outputs drop asynchronously, and the in-flight access gets no ack. The controller is reset on the same rst.

## Structure
- Shared package sdram_pkg holds:
  - arbiter state enum
  - ADDR_W and DATA_W defaults
  - controller command encodings, kept alongside for reuse
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and last_grant; outputs are valid and index. The FSM and datapath registers stay in sdram_arbiter.

## Test plan
- Single read, port 2, addr 0x012345; controller model returns 0xBEEF → mem_rereq high from cycle 2, req_ack[2] pulses once, resp_rdata = 0xBEEF.
- All 4 ports valid continuously with writes → grants in order 0,1,2,3,0, and no port is granted twice before the others.
- mem_busy held high 20 cycles (refresh) with port 1 valid → no mem_wrreq/mem_rereq during busy; issue 2 cycles after busy falls.
- Controller holds mem_done high 3 cycles → exactly one req_ack; next grant only after done and busy are both low.
- Controller never asserts done, TIMEOUT = 64 → timeout_err set after 64 cycles, req_ack pulses with resp_rdata = 0, next port is served.
- rst asserted while in WAIT_DONE → all outputs return to reset values immediately, no ack; after release, port 0 is granted first.
